ifetch: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Issues one instruction-memory read per cycle at the current PC and tells the PC stage when it may advance. Returns responses in order into a small instruction queue and hands `{pc, instr}` pairs to decode with valid/ready. Redirect flushes drop queued and in-flight fetches.

---
 rtl/ifetch.sv | 79 +++++++
 tb/tb_ifetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: fetch stage issuing one imem read per cycle, queueing {pc, instr} for decode; IFETCH_BYPASS_EN enables same-cycle response bypass
module ifetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_adv,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] af_mem [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_instr [DEPTH];
  logic [AW-1:0] af_wr, af_rd, q_wr, q_rd;
  logic [AW:0] outstanding, drop, q_count;
  logic [AW+1:0] used;
  logic [31:0] last_pc, last_instr;
  logic fire, keep, byp, q_empty, q_pop, q_push;
  assign q_empty = q_count == '0;
  assign keep = imem_rsp_valid && drop == '0 && !flush;
`ifdef IFETCH_BYPASS_EN
  assign byp = q_empty && keep;
`else
  assign byp = 1'b0;
`endif
  assign id_valid = !q_empty || byp;
  assign id_pc = !q_empty ? q_pc[q_rd] : byp ? af_mem[af_rd] : last_pc;
  assign id_instr = !q_empty ? q_instr[q_rd] : byp ? imem_rsp_data : last_instr;
  assign q_pop = id_ready && !q_empty;
  assign q_push = keep && !(byp && id_ready);
  // A decode pop frees its slot in the same cycle, so the credit counts the queue after the pop
  assign used = {1'b0, outstanding} + {1'b0, q_count} - (AW+2)'(q_pop);
  assign imem_req_valid = !rst && !flush && used < (AW+2)'(DEPTH);
  assign fire = imem_req_valid && imem_req_ready;
  assign pc_adv = fire;
  assign imem_req_addr = pc;
  // Storage arrays need no reset: pointers and counts decide what is live
  always_ff @(posedge clk) begin
    if (fire) af_mem[af_wr] <= pc;
    if (q_push) begin
      q_pc[q_wr] <= af_mem[af_rd];
      q_instr[q_wr] <= imem_rsp_data;
    end
  end
  // Pointers, counters, and the held decode outputs; flush empties the queue and marks in-flight reads as dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_wr <= '0;
      af_rd <= '0;
      q_wr <= '0;
      q_rd <= '0;
      q_count <= '0;
      outstanding <= '0;
      drop <= '0;
      last_pc <= '0;
      last_instr <= '0;
    end else begin
      af_wr <= af_wr + AW'(fire);
      af_rd <= af_rd + AW'(imem_rsp_valid);
      outstanding <= outstanding + (AW+1)'(fire) - (AW+1)'(imem_rsp_valid);
      drop <= flush ? outstanding - (AW+1)'(imem_rsp_valid) : drop - (AW+1)'(imem_rsp_valid && drop != '0);
      q_wr <= flush ? '0 : q_wr + AW'(q_push);
      q_rd <= flush ? '0 : q_rd + AW'(q_pop);
      q_count <= flush ? '0 : q_count + (AW+1)'(q_push) - (AW+1)'(q_pop);
      last_pc <= id_pc;
      last_instr <= id_instr;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench with an in-order latency memory model and an epoch-based expected decode stream
module tb_ifetch;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic [31:0] pc = 32'h100;
  logic flush = 0, imem_req_ready = 1, imem_rsp_valid = 0, id_ready = 1;
  logic [31:0] imem_rsp_data = 0;
  logic pc_adv, imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_instr, id_pc;
  typedef struct { logic [31:0] pc; int ep; int due; } fl_t;
  fl_t infl[$];
  logic [31:0] rq[$], got[$], got_i[$];
  logic [31:0] tgt = 0;
  int epoch = 0, cyc = 0, lat = 1, nfire = 0, first_cyc = -1;
  int checks = 0, failures = 0;

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_adv(pc_adv), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] gq(input int i);
    return got.size() > i ? got[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    #2 rst = 1;
    imem_rsp_valid = 0;
    #1;
    check("rst_pc_adv", 32'(pc_adv), 0);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_id_valid", 32'(id_valid), 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_instr", id_instr, 0);
    @(negedge clk);
    rst = 0;
    pc = start_pc;
    infl.delete(); rq.delete(); got.delete(); got_i.delete();
    epoch = 0; cyc = 0; nfire = 0; first_cyc = -1; flush = 0;
  endtask

  task automatic step();
    logic pop, erv, fire;
    logic [31:0] nxt;
    fl_t f;
    imem_rsp_valid = infl.size() > 0 && infl[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? word(infl[0].pc) : 32'h0;
    #1;
    pop = id_ready && rq.size() > 0;
    erv = !flush && (int'(infl.size()) + int'(rq.size()) - (pop ? 1 : 0)) < DEPTH;
    fire = erv && imem_req_ready;
    check("id_valid", 32'(id_valid), 32'(rq.size() > 0));
    if (rq.size() > 0) begin
      check("id_pc", id_pc, rq[0]);
      check("id_instr", id_instr, word(rq[0]));
    end
    check("req_valid", 32'(imem_req_valid), 32'(erv));
    check("pc_adv", 32'(pc_adv), 32'(fire));
    check("req_addr", imem_req_addr, pc);
    if (pop) begin
      if (first_cyc < 0) first_cyc = cyc;
      got.push_back(id_pc);
      got_i.push_back(id_instr);
    end
    @(posedge clk);
    if (pop) void'(rq.pop_front());
    if (flush) rq.delete();
    if (imem_rsp_valid) begin
      f = infl.pop_front();
      if (!flush && f.ep == epoch) rq.push_back(f.pc);
    end
    if (flush) epoch++;
    if (fire) begin
      infl.push_back('{pc, epoch, cyc + lat});
      nfire++;
    end
    nxt = flush ? tgt : fire ? pc + 32'd4 : pc;
    cyc++;
    @(negedge clk);
    pc = nxt;
    flush = 0;
  endtask

  initial begin
    #1;
    check("init_req_valid", 32'(imem_req_valid), 0);
    check("init_id_valid", 32'(id_valid), 0);
    @(negedge clk);
    rst = 0;
    // streaming, 1-cycle memory, decode always ready
    lat = 1; id_ready = 1; imem_req_ready = 1;
    for (int i = 0; i < 10; i++) step();
    check("t1_first_cycle", 32'(first_cyc), 2);
    check("t1_pc0", gq(0), 32'h100);
    check("t1_pc1", gq(1), 32'h104);
    check("t1_pc2", gq(2), 32'h108);
    check("t1_instr0", got_i.size() > 0 ? got_i[0] : 32'hFFFF_FFFF, 32'hDEAD_0100);
    check("t1_count", 32'(got.size()), 8);
    // mid-stream asynchronous reset, then credit limit with decode stalled
    do_reset(32'h100);
    id_ready = 0;
    for (int i = 0; i < 5; i++) step();
    check("t2_fires_full", 32'(nfire), 2);
    id_ready = 1;
    step();
    check("t2_fire_on_pop", 32'(nfire), 3);
    id_ready = 0;
    for (int i = 0; i < 3; i++) step();
    check("t2_fires_held", 32'(nfire), 3);
    id_ready = 1;
    for (int i = 0; i < 4; i++) step();
    // 3-cycle memory, flush with two reads in flight
    do_reset(32'h300);
    lat = 3;
    step(); step();
    flush = 1; tgt = 32'h200;
    step();
    for (int i = 0; i < 10; i++) step();
    check("t3_first_pc", gq(0), 32'h200);
    check("t3_first_instr", got_i.size() > 0 ? got_i[0] : 32'hFFFF_FFFF, 32'hDEAD_0200);
    // flush in the same cycle as a response
    do_reset(32'h400);
    lat = 2;
    step(); step();
    flush = 1; tgt = 32'h500;
    step();
    for (int i = 0; i < 8; i++) step();
    check("t4_first_pc", gq(0), 32'h500);
    check("t4_second_pc", gq(1), 32'h504);
    // flush while the queue holds entries and decode pops the head
    lat = 1; id_ready = 0;
    step(); step();
    id_ready = 1; flush = 1; tgt = 32'h700;
    step();
    for (int i = 0; i < 6; i++) step();
    // memory ready toggling
    do_reset(32'h600);
    lat = 1;
    foreach (got[i]) got.delete();
    for (int i = 0; i < 12; i++) begin
      imem_req_ready = (i % 3) != 1;
      step();
    end
    imem_req_ready = 1;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 5; i++) check($sformatf("t5_seq%0d", i), gq(i), 32'h600 + 32'(4 * i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
